// File: rtl/regfile_bus_if.sv
// regfile_bus_if
//    Bundles the core/host side of the register file: the core request
//    handshake, the completion writeback strobe and the host preload port.
//    master : core/host side. It drives requests, writeback and preload, and
//             receives rd_data, op_idx, ack and flag_c.
//    slave  : register file side. Its inputs and outputs are the reverse.
interface regfile_bus_if;
   logic [3:0] busreq;
   logic [3:0] sel;
   logic       done;
   logic [3:0] result;
   logic       carry;
   logic       load_en;
   logic [3:0] load_addr;
   logic [3:0] load_data;
   logic [3:0] rd_data;
   logic [3:0] op_idx;
   logic       ack;
   logic       flag_c;

   modport master (
      output busreq, sel, done, result, carry, load_en, load_addr, load_data,
      input  rd_data, op_idx, ack, flag_c
   );

   modport slave (
      input  busreq, sel, done, result, carry, load_en, load_addr, load_data,
      output rd_data, op_idx, ack, flag_c
   );
endinterface

// File: rtl/regfile_bus.sv
// regfile_bus
//    A 16 x 4-bit register file with a 1-bit carry flag. It serves a core
//    through a request/ack handshake. A read returns reg[sel], and a
//    next-operand request returns NEXT_OP. Each rising edge of done writes
//    result into reg[WB_REG] and carry into flag_c. A host preload port
//    writes with priority over that writeback.
//    Ports:
//       clk  : single clock; all state changes on its rising edge
//       rst  : synchronous active-high reset
//       bus  : regfile_bus_if.slave, which carries the request, writeback,
//              preload and response signals
module regfile_bus #(
   parameter logic [3:0] WB_REG  = 4'd3,
   parameter logic [3:0] NEXT_OP = 4'd3
) (
   input logic           clk,
   input logic           rst,
   regfile_bus_if.slave  bus
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_READ = 2'd1;
   localparam logic [1:0] ST_OPER = 2'd2;
   localparam logic [1:0] ST_HOLD = 2'd3;

   localparam logic [3:0] REQ_IDLE = 4'b0000;
   localparam logic [3:0] REQ_READ = 4'b0001;
   localparam logic [3:0] REQ_OPER = 4'b0011;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [3:0] regs_r [16];
   logic       flag_c_r;
   logic       done_q_r;
   logic [3:0] read_val_r;
   logic [3:0] rd_data_r;
   logic [3:0] op_idx_r;
   logic       ack_r;
   logic       wb_fire_s;
   logic       wb_write_s;

   // A writeback happens only on the rising edge of done. A preload to the
   // same register on that edge wins, and the writeback data is dropped.
   assign wb_fire_s  = bus.done & ~done_q_r;
   assign wb_write_s = wb_fire_s & ~(bus.load_en & (bus.load_addr == WB_REG));

   // Next-state logic for the request handshake
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.busreq == REQ_READ) begin
               state_nxt_s = ST_READ;
            end else if (bus.busreq == REQ_OPER) begin
               state_nxt_s = ST_OPER;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_READ: state_nxt_s = ST_HOLD;
         ST_OPER: state_nxt_s = ST_HOLD;
         ST_HOLD: begin
            if (bus.busreq == REQ_IDLE) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_HOLD;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Handshake state and registered response outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         read_val_r <= 4'd0;
         rd_data_r  <= 4'd0;
         op_idx_r   <= 4'd0;
         ack_r      <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         case (state_r)
            ST_IDLE: begin
               // Snapshot on the request edge. This gives read-old behaviour
               // when a write hits the same index on that edge.
               if (bus.busreq == REQ_READ) begin
                  read_val_r <= regs_r[bus.sel];
               end
            end
            ST_READ: begin
               rd_data_r <= read_val_r;
               ack_r     <= 1'b1;
            end
            ST_OPER: begin
               op_idx_r <= NEXT_OP;
               ack_r    <= 1'b1;
            end
            ST_HOLD: begin
               if (bus.busreq == REQ_IDLE) begin
                  ack_r <= 1'b0;
               end
            end
            default: ack_r <= 1'b0;
         endcase
      end
   end

   // Register storage, carry flag and done edge detector
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            regs_r[i] <= 4'd0;
         end
         flag_c_r <= 1'b0;
         done_q_r <= 1'b0;
      end else begin
         done_q_r <= bus.done;
         if (wb_fire_s) begin
            flag_c_r <= bus.carry;
         end
         if (wb_write_s) begin
            regs_r[WB_REG] <= bus.result;
         end
         if (bus.load_en) begin
            regs_r[bus.load_addr] <= bus.load_data;
         end
      end
   end

   assign bus.rd_data = rd_data_r;
   assign bus.op_idx  = op_idx_r;
   assign bus.ack     = ack_r;
   assign bus.flag_c  = flag_c_r;

endmodule

// File: tb/tb_regfile_bus.sv
module tb_regfile_bus;

   logic clk = 1'b0;
   logic rst;
   int   tests = 0;
   int   fails = 0;

   regfile_bus_if bus_if ();

   regfile_bus #(.WB_REG(4'd3), .NEXT_OP(4'd3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   logic [3:0] m_regs [16];
   logic       m_flag;
   logic       m_done_prev;
   logic       m_ack;
   logic [3:0] m_rd;
   logic [3:0] m_op;
   bit         m_due;       // a request was taken; its answer appears next edge
   bit         m_due_read;
   logic [3:0] m_snap;
   bit         m_busy;      // acknowledged, waiting for idle code
   bit         m_live = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      m_live = 1'b1;
      if (rst) begin
         for (int i = 0; i < 16; i++) m_regs[i] = 4'd0;
         m_flag = 1'b0; m_done_prev = 1'b0; m_ack = 1'b0;
         m_rd = 4'd0; m_op = 4'd0; m_due = 1'b0; m_busy = 1'b0;
         m_due_read = 1'b0; m_snap = 4'd0;
      end else begin
         if (m_due) begin
            m_ack = 1'b1;
            if (m_due_read) m_rd = m_snap; else m_op = 4'd3;
            m_due = 1'b0; m_busy = 1'b1;
         end else if (m_busy) begin
            if (bus_if.busreq == 4'b0000) begin m_ack = 1'b0; m_busy = 1'b0; end
         end else if (bus_if.busreq == 4'b0001) begin
            m_due = 1'b1; m_due_read = 1'b1; m_snap = m_regs[bus_if.sel];
         end else if (bus_if.busreq == 4'b0011) begin
            m_due = 1'b1; m_due_read = 1'b0;
         end
         if (bus_if.done && !m_done_prev) begin
            m_regs[3] = bus_if.result;
            m_flag = bus_if.carry;
         end
         if (bus_if.load_en) m_regs[bus_if.load_addr] = bus_if.load_data;
         m_done_prev = bus_if.done;
      end
   end

   // Compare DUT outputs with the model after every edge
   always @(posedge clk) begin
      #1;
      if (m_live) begin
         check("cyc_ack",    {7'd0, bus_if.ack},    {7'd0, m_ack});
         check("cyc_rd",     {4'd0, bus_if.rd_data}, {4'd0, m_rd});
         check("cyc_op",     {4'd0, bus_if.op_idx},  {4'd0, m_op});
         check("cyc_flag_c", {7'd0, bus_if.flag_c},  {7'd0, m_flag});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic load(input logic [3:0] a, input logic [3:0] d);
      bus_if.load_en = 1'b1; bus_if.load_addr = a; bus_if.load_data = d;
      cyc(1);
      bus_if.load_en = 1'b0;
   endtask

   // Full read handshake with literal latency checks
   task automatic do_read(input logic [3:0] s, input logic [3:0] exp, input string name);
      bus_if.busreq = 4'b0001; bus_if.sel = s;
      cyc(1);
      bus_if.load_en = 1'b0;
      check({name, "_lat1_ack"}, {7'd0, bus_if.ack}, 8'd0);
      cyc(1);
      check({name, "_ack"}, {7'd0, bus_if.ack}, 8'd1);
      check({name, "_rd"},  {4'd0, bus_if.rd_data}, {4'd0, exp});
      bus_if.busreq = 4'b0000;
      cyc(1);
      check({name, "_release"}, {7'd0, bus_if.ack}, 8'd0);
   endtask

   initial begin
      rst = 1'b1;
      bus_if.busreq = 4'b0000; bus_if.sel = 4'd0; bus_if.done = 1'b0;
      bus_if.result = 4'd0; bus_if.carry = 1'b0; bus_if.load_en = 1'b0;
      bus_if.load_addr = 4'd0; bus_if.load_data = 4'd0;
      cyc(2);
      check("rst_ack",    {7'd0, bus_if.ack},     8'd0);
      check("rst_rd",     {4'd0, bus_if.rd_data}, 8'd0);
      check("rst_op",     {4'd0, bus_if.op_idx},  8'd0);
      check("rst_flag_c", {7'd0, bus_if.flag_c},  8'd0);
      rst = 1'b0;

      // preload, including both ends of the index range
      load(4'd1, 4'd4); load(4'd2, 4'd5); load(4'd3, 4'd6); load(4'd4, 4'd3);
      load(4'd0, 4'hA); load(4'd15, 4'hE);
      check("model_reg2", {4'd0, m_regs[2]}, 8'd5);

      // read sel=2, request held through HOLD
      bus_if.busreq = 4'b0001; bus_if.sel = 4'd2;
      cyc(1);
      check("rd2_lat1", {7'd0, bus_if.ack}, 8'd0);
      cyc(1);
      check("rd2_ack", {7'd0, bus_if.ack}, 8'd1);
      check("rd2_val", {4'd0, bus_if.rd_data}, 8'd5);
      cyc(3);
      check("rd2_hold_ack", {7'd0, bus_if.ack}, 8'd1);
      check("rd2_hold_val", {4'd0, bus_if.rd_data}, 8'd5);
      bus_if.busreq = 4'b0000;
      cyc(1);
      check("rd2_release", {7'd0, bus_if.ack}, 8'd0);
      cyc(1);

      // next operand, then a read code held in HOLD is ignored
      bus_if.busreq = 4'b0011;
      cyc(2);
      check("oper_ack", {7'd0, bus_if.ack}, 8'd1);
      check("oper_idx", {4'd0, bus_if.op_idx}, 8'd3);
      bus_if.busreq = 4'b0001; bus_if.sel = 4'd1;
      cyc(4);
      check("oper_hold_ack", {7'd0, bus_if.ack}, 8'd1);
      check("oper_hold_rd",  {4'd0, bus_if.rd_data}, 8'd5);
      bus_if.busreq = 4'b0000;
      cyc(1);
      check("oper_release", {7'd0, bus_if.ack}, 8'd0);
      do_read(4'd15, 4'hE, "rd15");
      do_read(4'd0,  4'hA, "rd0");

      // one-cycle done pulse
      bus_if.done = 1'b1; bus_if.result = 4'd8; bus_if.carry = 1'b0;
      cyc(1);
      bus_if.done = 1'b0;
      cyc(1);
      do_read(4'd3, 4'd8, "wb8");
      check("wb8_flag", {7'd0, bus_if.flag_c}, 8'd0);

      // done held 4 cycles: one writeback
      bus_if.done = 1'b1; bus_if.result = 4'd5; bus_if.carry = 1'b1;
      cyc(4);
      bus_if.done = 1'b0;
      cyc(1);
      do_read(4'd3, 4'd5, "wb5");
      check("wb5_flag", {7'd0, bus_if.flag_c}, 8'd1);

      // a preload during held done must survive the remaining high cycles
      bus_if.done = 1'b1; bus_if.result = 4'd5; bus_if.carry = 1'b1;
      cyc(1);
      load(4'd3, 4'hC);
      cyc(2);
      bus_if.done = 1'b0;
      cyc(1);
      do_read(4'd3, 4'hC, "wb_once");

      // preload and writeback to the same register on one edge: preload wins
      bus_if.load_en = 1'b1; bus_if.load_addr = 4'd3; bus_if.load_data = 4'd9;
      bus_if.done = 1'b1; bus_if.result = 4'd2; bus_if.carry = 1'b1;
      cyc(1);
      bus_if.load_en = 1'b0; bus_if.done = 1'b0;
      cyc(1);
      do_read(4'd3, 4'd9, "prio");
      check("model_prio", {4'd0, m_regs[3]}, 8'd9);

      // preload and writeback to different registers: both land
      bus_if.load_en = 1'b1; bus_if.load_addr = 4'd5; bus_if.load_data = 4'd7;
      bus_if.done = 1'b1; bus_if.result = 4'hB; bus_if.carry = 1'b0;
      cyc(1);
      bus_if.load_en = 1'b0; bus_if.done = 1'b0;
      cyc(1);
      do_read(4'd3, 4'hB, "both_wb");
      do_read(4'd5, 4'd7, "both_ld");
      check("both_flag", {7'd0, bus_if.flag_c}, 8'd0);

      // read-old: a write to the read index on the request edge
      bus_if.load_en = 1'b1; bus_if.load_addr = 4'd4; bus_if.load_data = 4'hF;
      do_read(4'd4, 4'd3, "rd_old");
      do_read(4'd4, 4'hF, "rd_new");

      // unknown codes in IDLE
      bus_if.busreq = 4'b0101;
      cyc(2);
      check("unk5_ack", {7'd0, bus_if.ack}, 8'd0);
      bus_if.busreq = 4'b1111;
      cyc(2);
      check("unkF_ack", {7'd0, bus_if.ack}, 8'd0);
      bus_if.busreq = 4'b0000;
      cyc(1);
      do_read(4'd2, 4'd5, "unk_store");

      // reset during HOLD
      load(4'd7, 4'd6);
      bus_if.busreq = 4'b0001; bus_if.sel = 4'd7;
      cyc(2);
      check("hold6_rd", {4'd0, bus_if.rd_data}, 8'd6);
      rst = 1'b1; bus_if.busreq = 4'b0000;
      cyc(1);
      check("abort_ack",  {7'd0, bus_if.ack},     8'd0);
      check("abort_rd",   {4'd0, bus_if.rd_data}, 8'd0);
      check("abort_flag", {7'd0, bus_if.flag_c},  8'd0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) do_read(i[3:0], 4'd0, "clr");

      // reset during OPER
      bus_if.busreq = 4'b0011;
      cyc(1);
      rst = 1'b1; bus_if.busreq = 4'b0000;
      cyc(1);
      rst = 1'b0;
      cyc(1);
      check("abort_oper_ack", {7'd0, bus_if.ack}, 8'd0);
      check("abort_oper_op",  {4'd0, bus_if.op_idx}, 8'd0);

      cyc(2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
